// File: rtl/hlsm_mul_array_ref.sv
// Reference model of CHANNELS signed multiplier lanes (optionally multiply-accumulate)
// behind a Start/Busy/Done handshake with a fixed, parameterised latency.
module hlsm_mul_array_ref #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 4,
    parameter int MODE     = 0
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic                         Clr,
    input  logic [CHANNELS*WIDTH-1:0]    A,
    input  logic [CHANNELS*WIDTH-1:0]    B,
    output logic [CHANNELS*WIDTH-1:0]    Y,
    output logic                         Busy,
    output logic                         Done
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    accept;
    logic signed [WIDTH-1:0] a_p0 [CHANNELS];
    logic signed [WIDTH-1:0] b_p0 [CHANNELS];
    logic signed [WIDTH-1:0] y_p1 [CHANNELS];

    // Full-precision product, low WIDTH bits kept: the sum wraps modulo 2^WIDTH.
    function automatic logic signed [WIDTH-1:0] wrap_mac(
        input logic signed [WIDTH-1:0] acc,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] prod;
        prod = a * b;
        return acc + prod[WIDTH-1:0];
    endfunction

    assign accept = (state == IDLE) && Start;

    // Busy/Done are registered from the state, so the visible pulse trails DONE by one edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Busy <= (state != IDLE);
            Done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        cnt   <= CW'(LATENCY - 1);
                        state <= (LATENCY == 1) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0: operand capture at accept; inputs are free to change afterwards.
    always_ff @(posedge Clk) begin
        if (accept) begin
            for (int n = 0; n < CHANNELS; n++) begin
                a_p0[n] <= A[n*WIDTH +: WIDTH];
                b_p0[n] <= B[n*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p1: result register, written only on the edge that raises Done.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int n = 0; n < CHANNELS; n++)
                y_p1[n] <= '0;
        end else if (state == DONE) begin
            for (int n = 0; n < CHANNELS; n++)
                y_p1[n] <= wrap_mac((MODE == 1) ? y_p1[n] : '0, a_p0[n], b_p0[n]);
        end else if ((state == IDLE) && Clr && (MODE == 1)) begin
            for (int n = 0; n < CHANNELS; n++)
                y_p1[n] <= '0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign Y[g*WIDTH +: WIDTH] = y_p1[g];
    end

endmodule
